// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the dual-clock FIFO: issues reads only when space is
// guaranteed, absorbs the one-cycle read latency in a 2-entry buffer, emits a framed stream.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_error,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_sticky
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic              inflight;
    logic [WIDTH-1:0]  head_q, tail_q;
    logic [BEAT_W-1:0] beat;
    logic              pop, push;
    logic [1:0]        occ;

    assign pop     = m_valid & m_ready;
    assign push    = inflight;
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign occ     = cnt + {1'b0, inflight} - {1'b0, pop};
    assign m_valid = (cnt != 2'd0);
    assign m_data  = head_q;
    assign m_last  = m_valid & (beat == BEAT_MAX);

    always_comb begin
        fifo_rd_en = 1'b0;
        if (state == RUN && enable && !fifo_empty && occ < 2'd2)
            fifo_rd_en = 1'b1;
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable) state_nxt = RUN;
            RUN:   if (!enable) state_nxt = (cnt != 2'd0 || inflight) ? DRAIN : IDLE;
            DRAIN: begin
                if (enable)                           state_nxt = RUN;
                else if (cnt == 2'd0 && !inflight)    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Head is always the oldest word; the tail only holds a word when cnt = 2.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            cnt      <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            inflight <= fifo_rd_en;
            cnt      <= cnt + {1'b0, push} - {1'b0, pop};
            case ({push, pop})
                2'b10: if (cnt == 2'd0) head_q <= fifo_rd_data;
                       else             tail_q <= fifo_rd_data;
                2'b01: head_q <= tail_q;
                2'b11: if (cnt == 2'd1) head_q <= fifo_rd_data;
                       else begin
                           head_q <= tail_q;
                           tail_q <= fifo_rd_data;
                       end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            word_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (pop) begin
                beat     <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (fifo_error) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO (one-cycle read latency).
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_error;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [15:0] word_cnt;
    logic       err_sticky;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fm [0:63];
    int wp = 0;
    int rp = 0;
    int rd_pulses = 0;
    int bad_rd    = 0;
    int ovf       = 0;

    fifo_rd_stream #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(16)) dut (
        .rd_clk(rd_clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_error(fifo_error), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .word_cnt(word_cnt), .err_sticky(err_sticky)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (wp == rp);

    // FIFO model: data appears the cycle after an accepted read strobe.
    always @(posedge rd_clk) begin
        if (fifo_rd_en && wp != rp) begin
            fifo_rd_data <= fm[rp];
            rp <= rp + 1;
        end
    end

    always @(posedge rd_clk) begin
        if (!rst) begin
            if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
            if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
            if (dut.inflight && dut.cnt == 2'd2 && !(m_valid && m_ready)) ovf <= ovf + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        fm[wp] = d;
        wp++;
    endtask

    task automatic pulse_reset();
        @(negedge rd_clk);
        rst = 1'b1;
        @(negedge rd_clk);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int idx;
        logic [9:0] lastmask;

        // Reset with noisy inputs
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1; fifo_error = 1'b1;
        fifo_rd_data = 8'h00;
        repeat (3) @(negedge rd_clk);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_err", err_sticky, 0);
        check("rst_data", m_data, 0);
        check("rst_wcnt", word_cnt, 0);
        enable = 1'b0; m_ready = 1'b0; fifo_error = 1'b0;
        rst = 1'b0;
        push_word(8'h11);
        p0 = rd_pulses;
        repeat (3) @(negedge rd_clk);
        check("idle_no_rd", rd_pulses - p0, 0);
        rp_sync_skip: begin end
        // Consume the stray word so the single-word test starts with only 0xA5.
        enable = 1'b1; m_ready = 1'b1;
        repeat (5) @(negedge rd_clk);
        enable = 1'b0;
        pulse_reset();

        // Single word latency
        push_word(8'hA5);
        p0 = rd_pulses;
        enable = 1'b1; m_ready = 1'b1;
        @(negedge rd_clk);
        check("sw_rd_N", fifo_rd_en, 1);
        check("sw_valid_N", m_valid, 0);
        @(negedge rd_clk);
        check("sw_valid_N1", m_valid, 0);
        @(negedge rd_clk);
        check("sw_valid_N2", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'hA5});
        @(negedge rd_clk);
        check("sw_wcnt", word_cnt, 1);
        check("sw_pulses", rd_pulses - p0, 1);
        enable = 1'b0;
        pulse_reset();

        // Back-pressure
        p0 = rd_pulses;
        enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 20; i++) push_word(8'(i));
        repeat (6) @(negedge rd_clk);
        check("bp_pulses", rd_pulses - p0, 2);
        check("bp_hold", {m_valid, m_data}, {1'b1, 8'h00});
        check("bp_cnt", dut.cnt, 2);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_word", {m_valid, m_data}, {1'b1, 8'(i)});
            @(negedge rd_clk);
        end
        check("bp_empty", m_valid, 0);
        check("bp_wcnt", word_cnt, 20);
        check("bp_no_rd_empty", bad_rd, 0);
        enable = 1'b0;
        pulse_reset();

        // Framing, FRAME_LEN = 4
        for (int i = 0; i < 10; i++) push_word(8'h30 + 8'(i));
        enable = 1'b1; m_ready = 1'b1;
        idx = 0; lastmask = '0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            if (m_valid) begin
                lastmask[idx] = m_last;
                idx++;
            end
            @(negedge rd_clk);
        end
        check("fr_count", idx, 10);
        check("fr_lastmask", lastmask, 10'h088);
        check("fr_beat", dut.beat, 2);
        check("fr_wcnt", word_cnt, 10);
        enable = 1'b0;
        pulse_reset();

        // Enable drop while back-pressured
        for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
        p0 = rd_pulses;
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) @(negedge rd_clk);
        enable = 1'b0;
        repeat (3) @(negedge rd_clk);
        check("ed_pulses", rd_pulses - p0, 2);
        check("ed_drain", dut.state, 2);
        m_ready = 1'b1;
        check("ed_w0", {m_valid, m_data}, {1'b1, 8'h50});
        @(negedge rd_clk);
        check("ed_w1", {m_valid, m_data}, {1'b1, 8'h51});
        repeat (2) @(negedge rd_clk);
        check("ed_idle", {dut.state, m_valid}, {2'd0, 1'b0});
        check("ed_wcnt", word_cnt, 2);
        enable = 1'b1;
        @(negedge rd_clk);
        check("ed_rd_on", fifo_rd_en, 1);
        enable = 1'b0;
        #1;
        check("ed_rd_comb_off", fifo_rd_en, 0);
        @(negedge rd_clk);
        check("ed_back_idle", dut.state, 0);

        // Sticky error and async reset mid-burst
        fifo_error = 1'b1;
        @(negedge rd_clk);
        fifo_error = 1'b0;
        check("err_set", err_sticky, 1);
        repeat (3) @(negedge rd_clk);
        check("err_hold", err_sticky, 1);
        enable = 1'b1; m_ready = 1'b0;
        repeat (4) @(negedge rd_clk);
        check("mb_valid", m_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", m_valid, 0);
        check("async_err", err_sticky, 0);
        check("async_wcnt", word_cnt, 0);
        check("async_data", m_data, 0);
        check("async_rd", fifo_rd_en, 0);
        @(negedge rd_clk);
        rst = 1'b0; enable = 1'b0;
        @(negedge rd_clk);
        check("no_overflow", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
